message_bram_packer: RTL and testbench

- Packs variable-length probe messages (1..PORT_WIDTH bytes each) back to back into fixed-width BRAM words of PORT_WIDTH bytes.
- Drives the write side (address, data, write-enable) of a single-port BRAM.
- Sits between the probe message formatter and the trace BRAM in the pipeline probe.
- The transmit side reads words out byte 0 first.

---
 rtl/message_bram_packer.sv | 115 +++++++++++
 tb/tb_message_bram_packer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/message_bram_packer.sv
// Packs 1..PORT_WIDTH byte probe messages back to back into PORT_WIDTH-byte BRAM words.
// Optional trailing-word flush on en_in falling edge: define MESSAGE_BRAM_FLUSH_EN.
module message_bram_packer #(
   parameter int PORT_WIDTH = 7,
   parameter int BRAM_DEPTH = 1024,
   localparam int AW = $clog2(BRAM_DEPTH)
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    en_in,
   input  logic                    valid_in,
   input  logic [3:0]              length_in,
   input  logic [PORT_WIDTH*8-1:0] data_in,
   output logic [PORT_WIDTH*8-1:0] bram_din,
   output logic                    bram_we,
   output logic [AW-1:0]           bram_addr
);

   localparam int DW = PORT_WIDTH * 8;

   logic [DW-1:0] buf_q, buf_d;
   logic [DW-1:0] din_q, din_d;
   logic [DW-1:0] merged, overflow;
   logic [3:0]    fill_q, fill_d;
   logic [AW-1:0] cur_addr_q, cur_addr_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [AW-1:0] addr_inc;
   logic          we_q, we_d;
   logic          accept;
   int            fill_int;
   int            len_int;

`ifdef MESSAGE_BRAM_FLUSH_EN
   logic en_prev_q;
   logic flush;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) en_prev_q <= 1'b0;
      else        en_prev_q <= en_in;
   end

   assign flush = en_prev_q && !en_in && (fill_q != 4'd0);
`endif

   assign accept   = valid_in && en_in && (length_in != 4'd0);
   assign addr_inc = (cur_addr_q == AW'(BRAM_DEPTH - 1)) ? '0 : cur_addr_q + 1'b1;

   // Bytes past the fill pointer are held at zero, so the merge only has to insert new bytes.
   always_comb begin
      fill_int = int'(fill_q);
      len_int  = (int'(length_in) > PORT_WIDTH) ? PORT_WIDTH : int'(length_in);
      merged   = buf_q;
      overflow = '0;
      for (int k = 0; k < PORT_WIDTH; k++) begin
         if (k >= fill_int && k < fill_int + len_int) begin
            merged[8*k +: 8] = data_in[8*(k - fill_int) +: 8];
         end
         if (k < fill_int + len_int - PORT_WIDTH) begin
            overflow[8*k +: 8] = data_in[8*(k + PORT_WIDTH - fill_int) +: 8];
         end
      end
   end

   always_comb begin
      buf_d      = buf_q;
      fill_d     = fill_q;
      cur_addr_d = cur_addr_q;
      waddr_d    = waddr_q;
      din_d      = din_q;
      we_d       = 1'b0;
      if (accept) begin
         we_d    = 1'b1;
         din_d   = merged;
         waddr_d = cur_addr_q;
         if (fill_int + len_int >= PORT_WIDTH) begin
            cur_addr_d = addr_inc;
            buf_d      = overflow;
            fill_d     = 4'(fill_int + len_int - PORT_WIDTH);
         end else begin
            buf_d  = merged;
            fill_d = 4'(fill_int + len_int);
         end
      end
`ifdef MESSAGE_BRAM_FLUSH_EN
      else if (flush) begin
         we_d    = 1'b1;
         din_d   = buf_q;
         waddr_d = cur_addr_q;
      end
`endif
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         buf_q      <= '0;
         fill_q     <= '0;
         cur_addr_q <= '0;
         waddr_q    <= '0;
         din_q      <= '0;
         we_q       <= 1'b0;
      end else begin
         buf_q      <= buf_d;
         fill_q     <= fill_d;
         cur_addr_q <= cur_addr_d;
         waddr_q    <= waddr_d;
         din_q      <= din_d;
         we_q       <= we_d;
      end
   end

   assign bram_din  = din_q;
   assign bram_we   = we_q;
   assign bram_addr = we_q ? waddr_q : cur_addr_q;

endmodule

// File: tb/tb_message_bram_packer.sv
// Directed self-checking bench for message_bram_packer (PORT_WIDTH=7, BRAM_DEPTH=16).
module tb_message_bram_packer;

   localparam int PW = 7;
   localparam int DEPTH = 16;
   localparam int AW = 4;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          en_in;
   logic          valid_in;
   logic [3:0]    length_in;
   logic [PW*8-1:0] data_in;
   logic [PW*8-1:0] bram_din;
   logic          bram_we;
   logic [AW-1:0] bram_addr;

   int checks = 0;
   int failures = 0;

   message_bram_packer #(
      .PORT_WIDTH(PW),
      .BRAM_DEPTH(DEPTH)
   ) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .en_in    (en_in),
      .valid_in (valid_in),
      .length_in(length_in),
      .data_in  (data_in),
      .bram_din (bram_din),
      .bram_we  (bram_we),
      .bram_addr(bram_addr)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic exp_we, input logic [AW-1:0] exp_addr,
                      input logic [PW*8-1:0] exp_din, input logic check_din);
      checks++;
      assert (bram_we === exp_we) else begin
         failures++;
         $error("FAIL %s we: got %0b want %0b", tag, bram_we, exp_we);
      end
      checks++;
      assert (bram_addr === exp_addr) else begin
         failures++;
         $error("FAIL %s addr: got %0d want %0d", tag, bram_addr, exp_addr);
      end
      if (check_din) begin
         checks++;
         assert (bram_din === exp_din) else begin
            failures++;
            $error("FAIL %s din: got %h want %h", tag, bram_din, exp_din);
         end
      end
   endtask

   task automatic send(input logic [3:0] len, input logic [PW*8-1:0] data);
      valid_in  = 1'b1;
      length_in = len;
      data_in   = data;
      tick();
      valid_in  = 1'b0;
   endtask

   task automatic idle();
      valid_in = 1'b0;
      tick();
   endtask

   initial begin
      rst_in    = 1'b1;
      en_in     = 1'b0;
      valid_in  = 1'b0;
      length_in = 4'd0;
      data_in   = '0;
      #12;
      chk("reset", 1'b0, 4'd0, 56'h0, 1'b1);
      rst_in = 1'b0;
      tick();
      en_in = 1'b1;

      // 2-byte messages back to back
      send(4'd2, 56'hBBAA);
      chk("m1", 1'b1, 4'd0, 56'h0000000000BBAA, 1'b1);
      send(4'd2, 56'hDDCC);
      chk("m2", 1'b1, 4'd0, 56'h000000DDCCBBAA, 1'b1);
      send(4'd2, 56'hFFEE);
      chk("m3", 1'b1, 4'd0, 56'h00FFEEDDCCBBAA, 1'b1);

      // overflow into word 1
      send(4'd3, 56'h332211);
      chk("ovf", 1'b1, 4'd0, 56'h11FFEEDDCCBBAA, 1'b1);
      idle();
      chk("ovf_addr", 1'b0, 4'd1, 56'h0, 1'b0);
      send(4'd1, 56'h44);
      chk("m44", 1'b1, 4'd1, 56'h00000000443322, 1'b1);

      // disabled: valid ignored
      en_in = 1'b0;
      send(4'd3, 56'h777777);
`ifdef MESSAGE_BRAM_FLUSH_EN
      chk("dis_flush", 1'b1, 4'd1, 56'h00000000443322, 1'b1);
`else
      chk("dis", 1'b0, 4'd1, 56'h0, 1'b0);
`endif
      idle();
      chk("dis2", 1'b0, 4'd1, 56'h0, 1'b0);
      en_in = 1'b1;
      send(4'd1, 56'h55);
      chk("resume", 1'b1, 4'd1, 56'h00000055443322, 1'b1);

      // complete word 1, then whole-word messages
      send(4'd3, 56'h887766);
      chk("w1full", 1'b1, 4'd1, 56'h88776655443322, 1'b1);
      send(4'd0, 56'hFFFFFF);
      chk("len0", 1'b0, 4'd2, 56'h0, 1'b0);
      send(4'd9, 56'h0123456789ABCD);
      chk("len9", 1'b1, 4'd2, 56'h0123456789ABCD, 1'b1);
      for (int a = 3; a < 15; a++) begin
         send(4'd7, {8'(a), 48'h112233445566});
         chk("fill", 1'b1, 4'(a), {8'(a), 48'h112233445566}, 1'b1);
      end
      idle();
      chk("pre_last", 1'b0, 4'd15, 56'h0, 1'b0);
      send(4'd7, 56'hF0E0D0C0B0A090);
      chk("last", 1'b1, 4'd15, 56'hF0E0D0C0B0A090, 1'b1);
      idle();
      chk("wrap", 1'b0, 4'd0, 56'h0, 1'b0);
      send(4'd1, 56'h99);
      chk("wrap_wr", 1'b1, 4'd0, 56'h00000000000099, 1'b1);
      send(4'd2, 56'hBBAA);
      chk("fill3", 1'b1, 4'd0, 56'h00000000BBAA99, 1'b1);

      // partial word left when en_in falls
      en_in = 1'b0;
      idle();
`ifdef MESSAGE_BRAM_FLUSH_EN
      chk("flush", 1'b1, 4'd0, 56'h00000000BBAA99, 1'b1);
`else
      chk("noflush", 1'b0, 4'd0, 56'h0, 1'b0);
`endif
      idle();
      chk("after_fall", 1'b0, 4'd0, 56'h0, 1'b0);
      en_in = 1'b1;
      send(4'd1, 56'hCC);
      chk("retain", 1'b1, 4'd0, 56'h000000CCBBAA99, 1'b1);

      // async reset mid-operation
      send(4'd1, 56'hDD);
      chk("pre_rst", 1'b1, 4'd0, 56'h0000DDCCBBAA99, 1'b1);
      #2;
      rst_in = 1'b1;
      #1;
      chk("async_rst", 1'b0, 4'd0, 56'h0, 1'b1);
      #2;
      rst_in = 1'b0;
      send(4'd2, 56'h1234);
      chk("post_rst", 1'b1, 4'd0, 56'h00000000001234, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
